// File: rtl/sr_mul_seq_if.sv
// Issue/response bundle between the schoolRISCV decoder and the MUL sequencer.
// The decoder drives start/srcA/srcB; the sequencer answers with stall/done/result.
interface sr_mul_seq_if #(
    parameter int WIDTH = 32
);
    // start is held by the decoder for as long as the MUL sits in fetch.
    // stall=1 means "do not retire this cycle". done=1 is the single-cycle
    // write strobe during which result is the product.
    logic             start;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic [1:0]       dbg_state;

    modport master (
        output start,
        output srcA,
        output srcB,
        input  stall,
        input  done,
        input  result,
        input  busy,
        input  dbg_state
    );

    modport slave (
        input  start,
        input  srcA,
        input  srcB,
        output stall,
        output done,
        output result,
        output busy,
        output dbg_state
    );
endinterface

// File: rtl/sr_mul_seq.sv
// Iterative shift-add MUL engine for the schoolRISCV core: one multiplier bit
// per cycle, stalling the core until the low WIDTH product bits are ready.
module sr_mul_seq #(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    sr_mul_seq_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] mplier_shr;
    logic             last_bit;
    logic             no_more_bits;
    logic             stall_c;
    logic             done_c;
    logic             busy_c;

    assign mplier_shr   = mplier_q >> 1;
    assign last_bit     = (cnt_q == CNT_W'(WIDTH - 1));
    assign no_more_bits = (EARLY_EXIT != 0) && (mplier_shr == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        done_c   = 1'b0;
        busy_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The issuing cycle itself must already hold the PC.
                if (bus.start) begin
                    stall_c  = 1'b1;
                    acc_d    = '0;
                    mcand_d  = bus.srcA;
                    mplier_d = bus.srcB;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end

            S_BUSY: begin
                stall_c = 1'b1;
                busy_c  = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit || no_more_bits) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // start is still the same instruction here, so it is ignored.
                done_c  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // acc only changes on a load or while BUSY, so it doubles as the held result.
    assign bus.result    = acc_q;
    assign bus.stall     = stall_c;
    assign bus.done      = done_c;
    assign bus.busy      = busy_c;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sr_mul_seq.sv
// Bench for sr_mul_seq: one instance without and one with early exit, driven
// from a vector table plus hand-written reset, idle and back-to-back sequences.
module tb_sr_mul_seq;
    localparam int W = 32;

    typedef struct {
        bit          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [W-1:0] exp_q[$];

    sr_mul_seq_if #(.WIDTH(W)) if0 ();
    sr_mul_seq_if #(.WIDTH(W)) if1 ();

    sr_mul_seq #(.WIDTH(W), .EARLY_EXIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    sr_mul_seq #(.WIDTH(W), .EARLY_EXIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit sel, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            if1.start = s; if1.srcA = a; if1.srcB = b;
        end else begin
            if0.start = s; if0.srcA = a; if0.srcB = b;
        end
    endtask

    task automatic get_out(input bit sel, output logic st, output logic dn, output logic bs,
                           output logic [31:0] res);
        if (sel) begin
            st = if1.stall; dn = if1.done; bs = if1.busy; res = if1.result;
        end else begin
            st = if0.stall; dn = if0.done; bs = if0.busy; res = if0.result;
        end
    endtask

    function automatic int lat_ee(input logic [31:0] b);
        int k = 1;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        return k + 1;
    endfunction

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after DONE,
    // or one cycle later when start is released (to check the held result).
    task automatic mul_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input bit keep_start);
        int c = 0;
        bit got = 0;
        bit bad = 0;
        logic st, dn, bs;
        logic [31:0] res;
        set_in(sel, 1'b1, a, b);
        exp_q.push_back(exp_res);
        while (!got && c <= 80) begin
            @(negedge clk);
            get_out(sel, st, dn, bs, res);
            if (dn) begin
                got = 1;
                check("latency", c, exp_lat);
                check("result", res, exp_q.pop_front());
                check("done_excl", {st, bs}, 2'b00);
            end else if (!st || (c > 0 && !bs) || (c == 0 && bs)) begin
                bad = 1;
            end
            @(posedge clk); #1;
            c++;
            // Operands must be ignored once the sequence is running.
            if (!got) set_in(sel, 1'b1, $urandom, $urandom);
        end
        if (!got) begin
            check("timeout_no_done", 0, 1);
            void'(exp_q.pop_front());
        end
        check("stall_window", bad, 0);
        if (!keep_start) begin
            set_in(sel, 1'b0, $urandom, $urandom);
            @(negedge clk);
            get_out(sel, st, dn, bs, res);
            check("idle_after_done", {st, dn, bs}, 3'b000);
            check("result_hold", res, exp_res);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t        vecs[$];
        logic        st, dn, bs;
        logic [31:0] res;
        logic [31:0] ra, rb;
        bit          bad;

        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        set_in(0, 1'b0, '0, '0);
        set_in(1, 1'b0, '0, '0);

        vecs.push_back('{0, 32'd7,          32'd6,          32'd42,         33});
        vecs.push_back('{0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   33});
        vecs.push_back('{0, 32'h80000000,   32'd2,          32'd0,          33});
        vecs.push_back('{0, 32'hFFFFFFFF,   32'd0,          32'd0,          33});
        vecs.push_back('{1, 32'd5,          32'd2,          32'd10,         3});
        vecs.push_back('{1, 32'd123,        32'd0,          32'd0,          2});
        vecs.push_back('{1, 32'd1,          32'h80000000,   32'h80000000,   33});
        vecs.push_back('{1, 32'h1234,       32'h10,         32'h12340,      6});
        vecs.push_back('{1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   2});
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom_range(0, 32'h0FFF) << $urandom_range(0, 20);
            vecs.push_back('{0, ra, rb, ra * rb, 33});
            vecs.push_back('{1, ra, rb, ra * rb, lat_ee(rb)});
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        get_out(0, st, dn, bs, res);
        check("reset_ctrl0", {st, dn, bs}, 3'b000);
        check("reset_result0", res, 32'd0);
        get_out(1, st, dn, bs, res);
        check("reset_ctrl1", {st, dn, bs}, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle for 100 cycles with start low
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            get_out(0, st, dn, bs, res);
            if (st || dn || bs || res != 0) bad = 1;
            get_out(1, st, dn, bs, res);
            if (st || dn || bs || res != 0) bad = 1;
        end
        check("idle_100", bad, 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            mul_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat, 0);
        end

        // Back-to-back with start held across both DONE cycles
        mul_op(0, 32'd3, 32'd5, 32'd15, 33, 1);
        mul_op(0, 32'h10000, 32'h10000, 32'd0, 33, 0);
        mul_op(1, 32'd6, 32'd3, 32'd18, 3, 1);
        mul_op(1, 32'd7, 32'd4, 32'd28, 4, 0);

        // Reset in cycle 10 of a running multiply
        set_in(0, 1'b1, 32'd9, 32'd9);
        repeat (10) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        get_out(0, st, dn, bs, res);
        check("busy_before_reset", {st, bs}, 2'b11);
        rst_n = 1'b0;
        set_in(0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        get_out(0, st, dn, bs, res);
        check("midreset_ctrl", {st, dn, bs}, 3'b000);
        check("midreset_result", res, 32'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            get_out(0, st, dn, bs, res);
            if (st || dn || bs) bad = 1;
        end
        check("no_done_after_reset", bad, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
